input_buffer_ctrl: RTL and testbench
====================================

Name: input_buffer_ctrl

Overview:
Sequencer for the systolic array's skewed input buffer, the bank of per-lane shift registers where lane i delays by i cycles.
- Accepts one tile of activation rows from an upstream source using a valid/ready handshake, and drives the buffer's load_en for each row.
- Then asserts out_en long enough to flush every row through the diagonal skew into the array.
- Issues a one-cycle done pulse at the end.
- Supports back-pressure from the array (stall) and a synchronous abort.

Parameters:
ARRAY_WIDTH, 8, number of array lanes; equals the buffer lane count and sets the skew tail of ARRAY_WIDTH-1 cycles.
ROW_W, 4, width of num_rows; the maximum tile is 2^ROW_W-1 rows.

Ports:
clk  in  1  clock; all state changes on its rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  begin a tile; sampled only in IDLE.
num_rows  in  ROW_W  rows in the tile; latched when start is accepted.
abort  in  1  synchronous abort; return to IDLE.
in_valid  in  1  upstream has a row on the buffer's in_act bus.
in_ready  out  1  controller can accept a row.
stall  in  1  array back-pressure; freezes the drain.
load_en  out  1  to buffer: shift in the current row.
out_en  out  1  to buffer: advance the skew and present out_act.
out_first  out  1  qualifies the first out_en cycle of the tile.
out_last  out  1  qualifies the final out_en cycle of the tile.
busy  out  1  tile in progress (LOAD, DRAIN or DONE).
done  out  1  one-cycle pulse when the tile completes.

Behaviour:
- Reset: rst=1 forces state to IDLE and clears rows_q, load_cnt and drain_cnt immediately, without waiting for a clock edge. While rst is high, in_ready, load_en, out_en, out_first, out_last, busy and done are all 0.
- States: IDLE, LOAD, DRAIN, DONE, encoded in 2 bits.
- IDLE:
  - All outputs are 0.
  - On start=1: latch rows_q=num_rows and clear the counters.
  - Next state is LOAD if num_rows!=0, otherwise DONE.
- LOAD:
  - busy=1, in_ready=1.
  - load_en = in_valid & in_ready (combinational, same cycle).
  - Each accepted beat increments load_cnt.
  - The beat that makes load_cnt==rows_q moves the state to DRAIN on the next edge.
  - in_valid=0 cycles do not advance anything.
- DRAIN:
  - busy=1, in_ready=0.
  - out_en = ~stall.
  - Each out_en cycle increments drain_cnt.
  - Total out_en cycles = rows_q + ARRAY_WIDTH - 1.
  - out_first = out_en & (drain_cnt==0).
  - out_last = out_en & (drain_cnt == total-1).
  - The edge after the out_last cycle moves the state to DONE.
  - While stall=1: out_en=0 and the counter holds.
- DONE: busy=1, done=1 for exactly one cycle, then IDLE. A new tile can start from the following cycle.
- Counters: drain_cnt is sized to hold (2^ROW_W-1)+ARRAY_WIDTH-1. Counters never wrap within a tile. num_rows is ignored outside start acceptance.
- Ignored inputs:
  - start while busy is ignored: no relatch, no restart.
  - stall outside DRAIN is ignored.
  - in_valid outside LOAD is ignored, because in_ready=0 there.
- abort:
  - Takes priority over all other inputs in every state.
  - Next state is IDLE with counters cleared; done is not pulsed.
  - Outputs in the abort cycle follow the current state. For example, a load beat accepted in that cycle is still signalled on load_en.
- Simultaneous events:
  - abort together with the final load beat leads to IDLE.
  - stall together with what would be the out_last cycle: out_en=0 and out_last=0, and the state remains DRAIN.
- Latency: start edge to first load_en is 1 cycle with in_valid held high. Last load beat to first out_en is 1 cycle with no stall.

Test Plan:
1. ARRAY_WIDTH=8, num_rows=4, start at cycle 0, in_valid=1 constant, stall=0 -> load_en high on cycles 1–4; out_en high on cycles 5–15 (11 cycles); out_first at 5, out_last at 15; done only at 16; busy high on 1–16, 0 at 17.
2. num_rows=3, in_valid pattern 1,0,1,0,1 from cycle 1 -> exactly 3 load_en pulses (cycles 1, 3, 5); DRAIN entered at cycle 6; 10 out_en cycles; single done.
3. Scenario 1 with stall=1 on cycles 7–8 -> out_en low on 7–8 and still 11 out_en cycles in total; out_last at 17; done at 18.
4. num_rows=0 with start -> no load_en or out_en; busy and done high at cycle 1; IDLE at cycle 2.
5. abort at cycle 9 of scenario 1 -> cycle 10 has all outputs 0 and no done ever pulses; a new start at cycle 12 with num_rows=2 completes normally (done at 12+1+2+9 = cycle 24).
6. Async rst asserted mid-LOAD between clock edges -> all outputs 0 before the next edge. Also, start pulsed during DRAIN -> ignored, rows_q unchanged, and done occurs at the original cycle.

Source files
------------

// File: rtl/input_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : input_buffer_ctrl
//  Description : Sequencer for the systolic array's skewed input buffer.
//                Accepts one tile of activation rows over a valid/ready
//                handshake (load_en per row), then drives out_en for
//                rows + ARRAY_WIDTH - 1 cycles so every row clears the
//                diagonal skew. A one-cycle done pulse ends the tile.
//                The array can hold off the drain with stall. A synchronous
//                abort returns the sequencer to IDLE from any state.
//  Ports       : clk, rst (async, active-high)
//                start, num_rows, abort         - tile control
//                in_valid / in_ready            - upstream row handshake
//                stall                          - array back-pressure
//                load_en, out_en                - buffer controls
//                out_first, out_last            - drain window qualifiers
//                busy, done                     - status
//  Revision    : 1.0  initial release
// ============================================================================
module input_buffer_ctrl #(
    parameter int ARRAY_WIDTH = 8,
    parameter int ROW_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ROW_W-1:0] num_rows,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             stall,
    output logic             load_en,
    output logic             out_en,
    output logic             out_first,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    // Longest drain: largest tile plus the skew tail.
    localparam int DRAIN_MAX = (2**ROW_W - 1) + ARRAY_WIDTH - 1;
    localparam int DW        = $clog2(DRAIN_MAX + 1);

    localparam logic [DW-1:0] c_TAIL = DW'(ARRAY_WIDTH - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [ROW_W-1:0] r_rows;
    logic [ROW_W-1:0] r_load_cnt;
    logic [DW-1:0]    r_drain_cnt;

    logic [DW-1:0]    w_total;
    logic [DW-1:0]    w_last_idx;
    logic [ROW_W:0]   w_load_cnt_inc;
    logic             w_load_final;

    // Drain length is the row count plus the skew tail; rows >= 1 whenever
    // DRAIN is reached, so the last index never underflows.
    assign w_total        = DW'(r_rows) + c_TAIL;
    assign w_last_idx     = w_total - DW'(1);
    // One extra bit so the compare cannot alias on a full-size tile.
    assign w_load_cnt_inc = {1'b0, r_load_cnt} + (ROW_W+1)'(1);
    assign w_load_final   = load_en && (w_load_cnt_inc == {1'b0, r_rows});

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; abort overrides every state.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        w_next_state = (num_rows != '0) ? c_LOAD : c_DONE;
                    end
                end
                c_LOAD: begin
                    if (w_load_final) begin
                        w_next_state = c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    // out_last already folds in ~stall, so a stalled final
                    // cycle keeps us here.
                    if (out_last) begin
                        w_next_state = c_DONE;
                    end
                end
                default: begin
                    w_next_state = c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: pure functions of the current state and live inputs, so a
    // beat accepted in an abort cycle is still reported.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (r_state == c_LOAD);
        load_en   = (r_state == c_LOAD) && in_valid;
        out_en    = (r_state == c_DRAIN) && !stall;
        out_first = out_en && (r_drain_cnt == '0);
        out_last  = out_en && (r_drain_cnt == w_last_idx);
        busy      = (r_state != c_IDLE);
        done      = (r_state == c_DONE);
    end

    // ------------------------------------------------------------------
    // Tile size and beat counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rows      <= '0;
            r_load_cnt  <= '0;
            r_drain_cnt <= '0;
        end else if (abort) begin
            r_load_cnt  <= '0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_rows      <= num_rows;
                        r_load_cnt  <= '0;
                        r_drain_cnt <= '0;
                    end
                end
                c_LOAD: begin
                    if (load_en) begin
                        r_load_cnt <= r_load_cnt + ROW_W'(1);
                    end
                end
                c_DRAIN: begin
                    if (out_en) begin
                        r_drain_cnt <= r_drain_cnt + DW'(1);
                    end
                end
                default: begin
                    r_load_cnt  <= r_load_cnt;
                    r_drain_cnt <= r_drain_cnt;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_input_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_buffer_ctrl
//  Description : Self-checking bench for input_buffer_ctrl. A tile-level
//                reference model (rows still to load, drain cycles left)
//                predicts every output each cycle; directed tiles pin the
//                cycle-exact timeline, then randomized traffic follows.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_input_buffer_ctrl;

    localparam int AW = 8;
    localparam int RW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [RW-1:0] num_rows;
    logic          abort;
    logic          in_valid;
    logic          in_ready;
    logic          stall;
    logic          load_en;
    logic          out_en;
    logic          out_first;
    logic          out_last;
    logic          busy;
    logic          done;

    input_buffer_ctrl #(.ARRAY_WIDTH(AW), .ROW_W(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_rows  (num_rows),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .stall     (stall),
        .load_en   (load_en),
        .out_en    (out_en),
        .out_first (out_first),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Tile-level model: a tile is "rows still to accept" followed by
    // "drain beats still owed"; when both are zero while busy, the tile is
    // in its completion cycle.
    bit m_busy       = 1'b0;
    int m_rem_load   = 0;
    int m_drain_left = 0;
    int m_total      = 0;

    logic obs_out_en, obs_done, obs_load_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy       = 1'b0;
        m_rem_load   = 0;
        m_drain_left = 0;
        m_total      = 0;
    endtask

    // Entered at posedge+1; drives one cycle of inputs, checks all outputs
    // mid-cycle, advances the model, and returns at the next posedge+1.
    task automatic step(input bit s, input int n, input bit ab, input bit v, input bit st);
        bit e_ready, e_load, e_oe, e_first, e_last, e_done;
        start    = s;
        num_rows = RW'(n);
        abort    = ab;
        in_valid = v;
        stall    = st;
        #4;
        e_ready = m_busy && (m_rem_load > 0);
        e_load  = e_ready && v;
        e_oe    = m_busy && (m_rem_load == 0) && (m_drain_left > 0) && !st;
        e_first = e_oe && (m_drain_left == m_total);
        e_last  = e_oe && (m_drain_left == 1);
        e_done  = m_busy && (m_rem_load == 0) && (m_drain_left == 0);
        check("in_ready",  32'(in_ready),  32'(e_ready));
        check("load_en",   32'(load_en),   32'(e_load));
        check("out_en",    32'(out_en),    32'(e_oe));
        check("out_first", 32'(out_first), 32'(e_first));
        check("out_last",  32'(out_last),  32'(e_last));
        check("busy",      32'(busy),      32'(m_busy));
        check("done",      32'(done),      32'(e_done));
        obs_out_en  = out_en;
        obs_done    = done;
        obs_load_en = load_en;
        if (ab) begin
            model_reset();
        end else if (!m_busy) begin
            if (s) begin
                m_busy       = 1'b1;
                m_rem_load   = n;
                m_drain_left = (n != 0) ? n + AW - 1 : 0;
                m_total      = m_drain_left;
            end
        end else if (m_rem_load > 0) begin
            if (v) m_rem_load--;
        end else if (m_drain_left > 0) begin
            if (!st) m_drain_left--;
        end else begin
            m_busy = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Runs a tile started at cycle 0; counts out_en/load_en/done and notes
    // the cycle of the last done pulse.
    task automatic run_tile(input int n, input int st_lo, input int st_hi, input int restart_cyc,
                            input bit alt_valid, output int oe_cnt, output int ld_cnt,
                            output int done_cnt, output int done_at);
        oe_cnt = 0; ld_cnt = 0; done_cnt = 0; done_at = -1;
        for (int i = 0; i < 26; i++) begin
            bit s, v;
            int nn;
            s  = (i == 0) || (i == restart_cyc);
            nn = (i == 0) ? n : ((i == restart_cyc) ? 9 : 0);
            v  = alt_valid ? ((i >= 1 && i <= 5) ? (i % 2 == 1) : 1'b1) : 1'b1;
            step(s, nn, 1'b0, v, (i >= st_lo) && (i <= st_hi));
            if (obs_out_en)  oe_cnt++;
            if (obs_load_en) ld_cnt++;
            if (obs_done) begin
                done_cnt++;
                done_at = i;
            end
        end
    endtask

    initial begin
        int oe, ld, dc, da;
        rst = 1'b1; start = 1'b0; num_rows = '0; abort = 1'b0;
        in_valid = 1'b0; stall = 1'b0;
        #6;
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_done",     32'(done),     32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic 4-row tile.
        run_tile(4, -1, -1, -1, 1'b0, oe, ld, dc, da);
        check("s1_out_en_cnt", 32'(oe), 32'd11);
        check("s1_load_cnt",   32'(ld), 32'd4);
        check("s1_done_at",    32'(da), 32'd16);
        // Gapped upstream valid.
        run_tile(3, -1, -1, -1, 1'b1, oe, ld, dc, da);
        check("s2_load_cnt",   32'(ld), 32'd3);
        check("s2_out_en_cnt", 32'(oe), 32'd10);
        check("s2_done_cnt",   32'(dc), 32'd1);
        // Stall on cycles 7-8.
        run_tile(4, 7, 8, -1, 1'b0, oe, ld, dc, da);
        check("s3_out_en_cnt", 32'(oe), 32'd11);
        check("s3_done_at",    32'(da), 32'd18);
        // Empty tile.
        run_tile(0, -1, -1, -1, 1'b0, oe, ld, dc, da);
        check("s4_out_en_cnt", 32'(oe), 32'd0);
        check("s4_done_at",    32'(da), 32'd1);
        // start during DRAIN must not relatch or restart.
        run_tile(4, -1, -1, 8, 1'b0, oe, ld, dc, da);
        check("s6_done_at",    32'(da), 32'd16);
        check("s6_done_cnt",   32'(dc), 32'd1);

        // Abort at cycle 9, restart at 12 with 2 rows.
        dc = 0; da = -1;
        for (int i = 0; i < 28; i++) begin
            step((i == 0) || (i == 12), (i == 0) ? 4 : 2, i == 9, 1'b1, 1'b0);
            if (obs_done) begin
                dc++;
                da = i;
            end
        end
        check("s5_done_cnt", 32'(dc), 32'd1);
        check("s5_done_at",  32'(da), 32'd24);

        // Asynchronous reset mid-LOAD, between clock edges.
        step(1'b1, 5, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_load_en",  32'(load_en),  32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        check("arst_busy",     32'(busy),     32'd0);
        model_reset();
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 3) == 0, int'($urandom_range(0, 15)),
                 $urandom_range(0, 79) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
